// File: rtl/imm_ext_pipe_ctrl_if.sv
// Handshake bundle between IF/ID, the immediate-extension controller and ID/EX.
// The master drives instructions and consumes results; the slave is the controller.
interface imm_ext_pipe_ctrl_if;
   logic        flush;
   logic [31:0] instr;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ext_imm;
   logic [1:0]  ext_mode;
   logic        use_imm;
   logic        illegal;

   modport master (
      output flush, instr, in_valid, out_ready,
      input  in_ready, out_valid, ext_imm, ext_mode, use_imm, illegal
   );

   modport slave (
      input  flush, instr, in_valid, out_ready,
      output in_ready, out_valid, ext_imm, ext_mode, use_imm, illegal
   );
endinterface

// File: rtl/imm_ext_pipe_ctrl.sv
// ID-stage immediate extension: opcode decode into a 2-entry skid buffer that
// feeds the ID/EX boundary with valid/ready handshake, stall and flush.
module imm_ext_pipe_ctrl #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                clk,
   input  logic                reset,
   imm_ext_pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] imm;
      logic [1:0]  mode;
      logic        use_imm;
      logic        illegal;
   } entry_t;

   localparam logic [1:0] MODE_SIGN   = 2'd0;
   localparam logic [1:0] MODE_ZERO   = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   state_t      state_q, state_d;
   entry_t      head_q, head_d;
   entry_t      tail_q, tail_d;
   logic        in_ready_q, in_ready_d;

   logic [5:0]  opcode;
   logic [15:0] imm16;
   entry_t      dec;
   logic        accept;
   logic        dequeue;

   assign opcode = bus.instr[31:26];
   assign imm16  = bus.instr[15:0];

   always_comb begin
      dec = '0;
      unique case (opcode)
         6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b100011, 6'b101011: begin
            dec.imm     = {{16{imm16[15]}}, imm16};
            dec.mode    = MODE_SIGN;
            dec.use_imm = 1'b1;
         end
         6'b001100, 6'b001101, 6'b001110: begin
            dec.imm     = {16'h0000, imm16};
            dec.mode    = MODE_ZERO;
            dec.use_imm = 1'b1;
         end
         6'b001111: begin
            dec.imm     = {imm16, 16'h0000};
            dec.mode    = MODE_UPPER;
            dec.use_imm = 1'b1;
         end
         6'b000100, 6'b000101: begin
            dec.imm     = {{14{imm16[15]}}, imm16, 2'b00};
            dec.mode    = MODE_BRANCH;
            dec.use_imm = 1'b0;
         end
         6'b000000, 6'b000010: begin
            dec = '0;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // A flush discards the input presented in the same cycle.
   assign accept  = bus.in_valid & in_ready_q & ~bus.flush;
   assign dequeue = (state_q != ST_EMPTY) & bus.out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (bus.flush) begin
         state_d = ST_EMPTY;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  head_d  = dec;
               end
            end
            ST_ONE: begin
               if (accept && dequeue) begin
                  head_d = dec;
               end else if (accept) begin
                  state_d = ST_FULL;
                  tail_d  = dec;
               end else if (dequeue) begin
                  state_d = ST_EMPTY;
                  head_d  = '0;
               end
            end
            ST_FULL: begin
               if (dequeue) begin
                  state_d = ST_ONE;
                  head_d  = tail_q;
                  tail_d  = '0;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               head_d  = '0;
               tail_d  = '0;
            end
         endcase
      end
      // Registered ready keeps out_ready off the upstream timing path.
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.ext_imm   = head_q.imm;
   assign bus.ext_mode  = head_q.mode;
   assign bus.use_imm   = head_q.use_imm;
   assign bus.illegal   = head_q.illegal;

endmodule

// File: tb/tb_imm_ext_pipe_ctrl.sv
// Bench for imm_ext_pipe_ctrl: a queue-based reference checked every cycle,
// plus directed literal expectations for each extension mode and corner case.
module tb_imm_ext_pipe_ctrl;

   typedef struct packed {
      logic [31:0] imm;
      logic [1:0]  mode;
      logic        use_imm;
      logic        illegal;
   } ent_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   logic check_en;
   ent_t mq[$];

   imm_ext_pipe_ctrl_if bus();

   imm_ext_pipe_ctrl #(.DATA_W(32), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t model_dec(logic [31:0] ins);
      ent_t e;
      int   op;
      logic signed [31:0] s;
      e  = '0;
      op = int'(ins[31:26]);
      s  = $signed(ins[15:0]);
      case (op)
         8, 9, 10, 11, 35, 43: begin e.imm = s;                    e.mode = 2'd0; e.use_imm = 1'b1; end
         12, 13, 14:           begin e.imm = 32'(ins[15:0]);       e.mode = 2'd1; e.use_imm = 1'b1; end
         15:                   begin e.imm = 32'(ins[15:0]) * 65536; e.mode = 2'd2; e.use_imm = 1'b1; end
         4, 5:                 begin e.imm = s * 4;                e.mode = 2'd3; e.use_imm = 1'b0; end
         0, 2:                 e = '0;
         default:              e.illegal = 1'b1;
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: occupancy is simply the queue length.
   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
      end else begin
         bit deq, acc;
         deq = (mq.size() > 0) && bus.out_ready;
         acc = bus.in_valid && (mq.size() < 2) && !bus.flush;
         if (bus.flush) begin
            mq.delete();
         end else begin
            if (deq) void'(mq.pop_front());
            if (acc) mq.push_back(model_dec(bus.instr));
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         ent_t h;
         h = (mq.size() > 0) ? mq[0] : '0;
         chk("model_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
         chk("model_in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
         chk("model_ext_imm",   bus.ext_imm,        h.imm);
         chk("model_ext_mode",  32'(bus.ext_mode),  32'(h.mode));
         chk("model_use_imm",   32'(bus.use_imm),   32'(h.use_imm));
         chk("model_illegal",   32'(bus.illegal),   32'(h.illegal));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string tag, input logic ov, input logic ir,
                      input logic [31:0] imm, input logic [1:0] mode,
                      input logic ui, input logic ill);
      @(negedge clk);
      $display("txn %s: out_valid=%0b in_ready=%0b ext_imm=0x%08h mode=%0d use_imm=%0b illegal=%0b",
               tag, bus.out_valid, bus.in_ready, bus.ext_imm, bus.ext_mode, bus.use_imm, bus.illegal);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(ir));
      chk({tag, "_ext_imm"},   bus.ext_imm,        imm);
      chk({tag, "_ext_mode"},  32'(bus.ext_mode),  32'(mode));
      chk({tag, "_use_imm"},   32'(bus.use_imm),   32'(ui));
      chk({tag, "_illegal"},   32'(bus.illegal),   32'(ill));
   endtask

   logic [5:0] ops [8];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      check_en = 1'b0;
      ops[0] = 6'b001000; ops[1] = 6'b001101; ops[2] = 6'b001111; ops[3] = 6'b000101;
      ops[4] = 6'b000000; ops[5] = 6'b111111; ops[6] = 6'b100011; ops[7] = 6'b001110;
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.instr = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check_en = 1'b1;
      lit("reset", 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);

      // Back-to-back stream covering every mode.
      bus.instr = 32'h2001_8001; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      tick(); bus.instr = 32'h3401_8001;
      lit("addi", 1'b1, 1'b1, 32'hFFFF_8001, 2'd0, 1'b1, 1'b0);
      tick(); bus.instr = 32'h3C01_1234;
      lit("ori", 1'b1, 1'b1, 32'h0000_8001, 2'd1, 1'b1, 1'b0);
      tick(); bus.instr = 32'h1000_FFFF;
      lit("lui", 1'b1, 1'b1, 32'h1234_0000, 2'd2, 1'b1, 1'b0);
      tick(); bus.instr = 32'hFC00_1234;
      lit("beq", 1'b1, 1'b1, 32'hFFFF_FFFC, 2'd3, 1'b0, 1'b0);
      tick(); bus.in_valid = 1'b0;
      lit("illegal", 1'b1, 1'b1, 32'h0, 2'd0, 1'b0, 1'b1);
      tick();
      lit("drained", 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);

      // Backpressure: two accepts fill the buffer, the third is held upstream.
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = 32'h2001_0001;
      tick(); bus.instr = 32'h2001_0002;
      tick(); bus.instr = 32'h2001_0003;
      lit("full", 1'b1, 1'b0, 32'h1, 2'd0, 1'b1, 1'b0);
      tick(); tick();
      lit("stall", 1'b1, 1'b0, 32'h1, 2'd0, 1'b1, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      lit("bp2", 1'b1, 1'b1, 32'h2, 2'd0, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      lit("bp3", 1'b1, 1'b1, 32'h3, 2'd0, 1'b1, 1'b0);
      tick();
      lit("bp_empty", 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);

      // Flush while full with a valid input in the flush cycle.
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = 32'h3001_0005;
      tick(); bus.instr = 32'h3001_0006;
      tick(); bus.instr = 32'h3001_0007; bus.flush = 1'b1;
      tick(); bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      lit("flush", 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);
      tick();
      lit("flush_gone", 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);

      // Reset while full, with flush and input also active.
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = 32'h1400_0010;
      tick(); bus.instr = 32'h3C01_ABCD;
      tick(); bus.instr = 32'h2001_7777; reset = 1'b1; bus.flush = 1'b1;
      tick(); reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
      lit("reset_mid", 1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);

      // Mixed traffic with varying stall and a flush, checked by the reference.
      for (int i = 0; i < 48; i++) begin
         bus.instr     = {ops[i % 8], 10'(i * 37), 16'(i * 16'h1357 + 16'h8000 * (i % 2))};
         bus.in_valid  = (i % 3) != 2;
         bus.out_ready = (i % 4) != 0 && (i % 11) != 5;
         bus.flush     = (i == 29);
         tick();
      end
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      tick(); tick(); tick();
      @(negedge clk);
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe_ctrl.md
Name: imm_ext_pipe_ctrl

Overview:
- ID-stage controller that sequences immediate extension for the pipelined datapath.
- Decodes the opcode of each incoming instruction and selects the extension mode: sign, zero, upper (LUI) or branch (sign-extend, then shift left 2). Produces the 32-bit immediate and a use-immediate flag.
- Delivers results to the ID/EX boundary through a 2-entry skid buffer with valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, instruction and extended-immediate width (fixed at 32; other values unsupported)
- DEPTH, 2, skid-buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush (branch/jump redirect)
- instr  input  32  instruction from IF/ID
- in_valid  input  1  instr is valid
- in_ready  output  1  block can accept instr this cycle
- out_valid  output  1  head entry valid toward ID/EX
- out_ready  input  1  ID/EX accepts head entry (0 = stall)
- ext_imm  output  32  extended immediate of head entry
- ext_mode  output  2  head mode: 0 sign, 1 zero, 2 upper, 3 branch
- use_imm  output  1  head instruction consumes the immediate (ALUSrc)
- illegal  output  1  head opcode is not recognised

Behaviour:
- Opcode decode from instr[31:26]; imm = instr[15:0].
  - Sign mode (0): 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu, 100011 lw, 101011 sw. ext_imm = {16{imm[15]}, imm}; use_imm=1.
  - Zero mode (1): 001100 andi, 001101 ori, 001110 xori. ext_imm = {16'h0, imm}; use_imm=1.
  - Upper mode (2): 001111 lui. ext_imm = {imm, 16'h0}; use_imm=1.
  - Branch mode (3): 000100 beq, 000101 bne. ext_imm = {14{imm[15]}, imm, 2'b00}; use_imm=0.
  - 000000 R-type and 000010 j: ext_imm=0, ext_mode=0, use_imm=0, illegal=0.
  - Any other opcode: ext_imm=0, ext_mode=0, use_imm=0, illegal=1.
- Decode is combinational on instr. Decoded fields are stored per entry on accept.
- Handshake:
  - Accept when in_valid & in_ready.
  - Dequeue when out_valid & out_ready.
  - in_valid is ignored when in_ready=0; the upstream stage must hold instr.
- Occupancy FSM:
  - States: EMPTY (0 entries), ONE (1), FULL (2).
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; dequeue only -> EMPTY; accept and dequeue together -> ONE (head replaced by new entry).
  - FULL: dequeue -> ONE (second entry becomes head). No accept possible.
- Outputs:
  - in_ready = (state != FULL). It is registered, derived from the state only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - Output fields come from the head register.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1). Throughput is 1 per cycle with no bubbles while out_ready=1.
- Order is strictly FIFO.
- Reset (synchronous):
  - state=EMPTY, in_ready=1, out_valid=0.
  - ext_imm=0, ext_mode=0, use_imm=0, illegal=0.
  - Reset has priority over flush and handshakes and discards entries mid-operation.
- Flush:
  - Next state is EMPTY, all entries are invalidated, and head fields are cleared to 0.
  - An input presented in the flush cycle is discarded even if in_valid=1. A dequeue in the flush cycle still counts downstream.
  - in_ready=1 in the cycle after a flush.
- Field values of empty entries are 0 (outputs are 0 whenever out_valid=0).

Test Plan:
- Sign extension: instr=0x2001_8001 (addi), out_ready=1 -> next cycle out_valid=1, ext_imm=0xFFFF_8001, ext_mode=0, use_imm=1.
- Zero and upper modes: ori instr=0x3401_8001 -> ext_imm=0x0000_8001, mode=1. Then lui instr=0x3C01_1234 -> ext_imm=0x1234_0000, mode=2. Back-to-back with no bubbles.
- Branch and illegal: beq instr=0x1000_FFFF -> ext_imm=0xFFFF_FFFC, mode=3, use_imm=0. Opcode 0x3F -> illegal=1, ext_imm=0.
- Backpressure: out_ready=0, push addi imm 0x0001 then 0x0002 -> in_ready=0 after 2 accepts, third instr held. Raise out_ready -> outputs 0x1, 0x2, then the third, in order with none lost.
- Flush: FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, outputs 0, and the flush-cycle input never appears.
- Reset mid-stream: reset asserted while FULL and flush=1 -> next cycle EMPTY, all outputs 0, in_ready=1.
